game_settings_reader: RTL and testbench
=======================================

# game_settings_reader

Wishbone initiator that fetches the nine game-setup registers from the main FSM's settings slave and caches them as parallel outputs for board, timer and counter logic. A `fetch` pulse starts a sequential read burst over the fixed register map. Completion is flagged with `settings_valid` and a one-cycle `done`. A stall-timeout abort keeps the reader from hanging while the slave holds `stall_i` (MENU state).

## Interface
Parameters:
- WAIT_LIMIT, 1023: maximum consecutive stalled request cycles per register before abort.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch  in  1  start pulse; sampled only in IDLE.
- game_settings  wishbone_if.master  bundle  drives stb_o, we_o, adr_o[7:0]; samples stall_i, ack_i, dat_i[15:0].
- row_column_number  out  16  cached value of address 0x00.
- mine_num  out  16  cached value of address 0x02.
- timer_seconds  out  16  cached value of address 0x04.
- field_size  out  16  cached value of address 0x08.
- board_size  out  16  cached value of address 0x0A.
- board_xpos  out  16  cached value of address 0x0C.
- board_ypos  out  16  cached value of address 0x0E.
- games_won  out  16  cached value of address 0x10.
- games_lost  out  16  cached value of address 0x12.
- busy  out  1  high while a burst is in progress.
- settings_valid  out  1  high once all nine registers are captured; low during a burst.
- done  out  1  one-cycle pulse on successful burst completion.
- timeout_err  out  1  sticky abort flag; cleared by the next accepted fetch.

## Operation
- Reset: all outputs 0; stb_o=0, we_o=0, adr_o=0x00; index=0; wait counter=0; state IDLE.
- Read sequence, index 0..8: 0x00, 0x02, 0x04, 0x08, 0x0A, 0x0C, 0x0E, 0x10, 0x12. Address 0x06 is never issued. we_o is always 0.
- FSM states:
  - IDLE: on fetch=1, go to REQ with index=0. Set busy=1, clear settings_valid and timeout_err, clear wait counter.
  - REQ: stb_o=1, adr_o=map[index].
    - ack_i=1: go to CAPTURE; stb_o drops next cycle.
    - Otherwise stall: increment wait counter. On reaching WAIT_LIMIT, go to IDLE with timeout_err=1 and busy=0; settings_valid stays 0.
  - CAPTURE: stb_o=0; latch dat_i into the output selected by index; reset wait counter.
    - index==8: go to IDLE; settings_valid=1, done=1 for one cycle, busy=0.
    - Otherwise: index+1, go to REQ.
- The slave acks combinationally (ack_i = !stall_i && stb_o) and registers dat_i on the ack edge. Data is therefore taken in CAPTURE, never in the ack cycle.
- Cached outputs keep their previous values during a burst until overwritten. A timeout leaves a partial mix, flagged by settings_valid=0.
- fetch while busy: ignored, not queued.
- The value 0xDEAD is stored like any other value; no error check.
- Wait counter: width clog2(WAIT_LIMIT+1), saturating, no wrap.

## Timing
- fetch high in cycle 0 → stb_o high in cycle 1.
- No-stall burst: 2 cycles per register, 18 cycles total; done and settings_valid high in cycle 19.
- Each stalled cycle adds exactly one cycle. stb_o and adr_o are held stable throughout the stall.
- stall_i rising in the CAPTURE cycle does not affect capture.
- rst mid-burst: next cycle stb_o=0 and all outputs 0; no resumption.
- done is never high in the same cycle as timeout_err rising.

## Test plan
- Easy-level slave values, stall_i=0, fetch pulse at cycle 0 → nine reads at 0x00…0x12 skipping 0x06; outputs match the slave; done pulses at cycle 19; stb_o high on odd cycles 1–17.
- stall_i=1 for the first 5 cycles of the burst → adr_o held at 0x00 with stb_o=1 for 5 extra cycles; completion at cycle 24; values correct.
- stall_i stuck at 1 with WAIT_LIMIT=16 → timeout_err=1 and busy=0 after 16 stalled cycles; settings_valid=0; no done pulse.
- Second fetch asserted at cycle 5 of a burst → ignored; exactly one burst, one done.
- games_won changes 3→4 in the slave, then a new fetch → settings_valid low during the burst; games_won=4 afterwards; other outputs unchanged.
- rst asserted at cycle 9 of a burst → from cycle 10, stb_o=0, busy=0 and all cached outputs 0; a fetch afterwards completes normally.

Source files
------------

// File: rtl/game_settings_reader_if.sv
// ---------------------------------------------------------------------------
// wishbone_if
//   Single-master pipelined Wishbone read bundle shared by the settings reader
//   (master) and the main FSM's settings register slave.
//   stb_o   : request strobe, held while the slave stalls
//   we_o    : write enable (this bus is read-only, always 0 from the reader)
//   adr_o   : 8-bit byte address of the requested register
//   stall_i : slave not ready to accept the request
//   ack_i   : slave accepted the request this cycle
//   dat_i   : read data, registered by the slave on the ack edge
// ---------------------------------------------------------------------------
interface wishbone_if;
    logic        stb_o;
    logic        we_o;
    logic [7:0]  adr_o;
    logic        stall_i;
    logic        ack_i;
    logic [15:0] dat_i;

    modport master (output stb_o, we_o, adr_o, input stall_i, ack_i, dat_i);
    modport slave  (input stb_o, we_o, adr_o, output stall_i, ack_i, dat_i);
endinterface

// File: rtl/game_settings_reader.sv
// ---------------------------------------------------------------------------
// game_settings_reader
//   Wishbone read initiator that fetches the nine game-setup registers from
//   the settings slave and caches them as parallel outputs.
//   clk, rst          : clock and synchronous active-high reset
//   fetch             : start pulse, only honoured while idle
//   game_settings     : Wishbone master port (stb/we/adr out, stall/ack/dat in)
//   row_column_number .. games_lost : cached register values
//   busy              : burst in progress
//   settings_valid    : all nine registers captured by the last burst
//   done              : one-cycle pulse on successful burst completion
//   timeout_err       : sticky stall-timeout flag, cleared by the next fetch
// ---------------------------------------------------------------------------
module game_settings_reader #(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch,
    wishbone_if.master       game_settings,
    output logic [15:0]      row_column_number,
    output logic [15:0]      mine_num,
    output logic [15:0]      timer_seconds,
    output logic [15:0]      field_size,
    output logic [15:0]      board_size,
    output logic [15:0]      board_xpos,
    output logic [15:0]      board_ypos,
    output logic [15:0]      games_won,
    output logic [15:0]      games_lost,
    output logic             busy,
    output logic             settings_valid,
    output logic             done,
    output logic             timeout_err
);
    localparam int WCW       = $clog2(WAIT_LIMIT + 1);
    localparam logic [3:0] LAST_IDX = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, CAPTURE} state_t;

    state_t           state, state_next;
    logic [3:0]       index;
    logic [WCW-1:0]   wait_cnt;
    logic [WCW-1:0]   wait_inc;
    logic             stall_abort;

    // Register map walked by index; 0x06 is a hole in the slave's map.
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    reg_addr = 8'h00;
            4'd1:    reg_addr = 8'h02;
            4'd2:    reg_addr = 8'h04;
            4'd3:    reg_addr = 8'h08;
            4'd4:    reg_addr = 8'h0A;
            4'd5:    reg_addr = 8'h0C;
            4'd6:    reg_addr = 8'h0E;
            4'd7:    reg_addr = 8'h10;
            default: reg_addr = 8'h12;
        endcase
    endfunction

    // Saturating increment; the abort fires when this cycle is the
    // WAIT_LIMIT-th consecutive stalled request cycle.
    assign wait_inc    = (wait_cnt == WCW'(WAIT_LIMIT)) ? wait_cnt : wait_cnt + 1'b1;
    assign stall_abort = (wait_inc == WCW'(WAIT_LIMIT));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (fetch) state_next = REQ;
            REQ: begin
                if (game_settings.ack_i)  state_next = CAPTURE;
                else if (stall_abort)     state_next = IDLE;
            end
            CAPTURE: state_next = (index == LAST_IDX) ? IDLE : REQ;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs decoded from state; adr_o follows index so it is held
    // stable for the whole stalled request.
    always_comb begin
        game_settings.stb_o = (state == REQ);
        game_settings.we_o  = 1'b0;
        game_settings.adr_o = reg_addr(index);
        busy                = (state != IDLE);
    end

    // Datapath: index, wait counter, cached values and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the cached values are plain registers (not a RAM), so they
            // are all reset to give downstream logic a defined zero state.
            index             <= '0;
            wait_cnt          <= '0;
            row_column_number <= '0;
            mine_num          <= '0;
            timer_seconds     <= '0;
            field_size        <= '0;
            board_size        <= '0;
            board_xpos        <= '0;
            board_ypos        <= '0;
            games_won         <= '0;
            games_lost        <= '0;
            settings_valid    <= 1'b0;
            done              <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch) begin
                        index          <= '0;
                        wait_cnt       <= '0;
                        settings_valid <= 1'b0;
                        timeout_err    <= 1'b0;
                    end
                end
                REQ: begin
                    if (!game_settings.ack_i) begin
                        wait_cnt <= wait_inc;
                        if (stall_abort) timeout_err <= 1'b1;
                    end
                end
                CAPTURE: begin
                    // The slave registered dat_i on the ack edge, so data is
                    // taken here rather than in the ack cycle.
                    wait_cnt <= '0;
                    case (index)
                        4'd0:    row_column_number <= game_settings.dat_i;
                        4'd1:    mine_num          <= game_settings.dat_i;
                        4'd2:    timer_seconds     <= game_settings.dat_i;
                        4'd3:    field_size        <= game_settings.dat_i;
                        4'd4:    board_size        <= game_settings.dat_i;
                        4'd5:    board_xpos        <= game_settings.dat_i;
                        4'd6:    board_ypos        <= game_settings.dat_i;
                        4'd7:    games_won         <= game_settings.dat_i;
                        default: games_lost        <= game_settings.dat_i;
                    endcase
                    if (index == LAST_IDX) begin
                        settings_valid <= 1'b1;
                        done           <= 1'b1;
                    end else begin
                        index <= index + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_settings_reader.sv
// ---------------------------------------------------------------------------
// tb_game_settings_reader
//   Bench for game_settings_reader with a behavioural settings slave
//   (combinational ack, data registered on the ack edge). Expected register
//   reads are queued when a burst is launched and drained against the reads
//   the DUT actually issued and the values it cached.
// ---------------------------------------------------------------------------
module tb_game_settings_reader;
    localparam int WL = 16;

    logic clk = 1'b0;
    logic rst, fetch, stall;
    logic [15:0] row_column_number, mine_num, timer_seconds, field_size;
    logic [15:0] board_size, board_xpos, board_ypos, games_won, games_lost;
    logic busy, settings_valid, done, timeout_err;

    wishbone_if gs();

    game_settings_reader #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .game_settings(gs),
        .row_column_number(row_column_number), .mine_num(mine_num),
        .timer_seconds(timer_seconds), .field_size(field_size),
        .board_size(board_size), .board_xpos(board_xpos),
        .board_ypos(board_ypos), .games_won(games_won), .games_lost(games_lost),
        .busy(busy), .settings_valid(settings_valid), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Settings slave model.
    logic [15:0] mem [0:255];
    logic [15:0] slave_dat;
    assign gs.stall_i = stall;
    assign gs.ack_i   = !stall && gs.stb_o;
    assign gs.dat_i   = slave_dat;
    always @(posedge clk) if (gs.ack_i) slave_dat <= mem[gs.adr_o];

    // Scoreboard.
    typedef struct { logic [7:0] adr; logic [15:0] dat; } exp_t;
    exp_t exp_q[$];
    logic [7:0] ack_q[$];
    logic [7:0] addr_tbl [0:8] = '{8'h00, 8'h02, 8'h04, 8'h08, 8'h0A,
                                   8'h0C, 8'h0E, 8'h10, 8'h12};

    // Per-cycle history of one observation window (cycle 0 = fetch cycle).
    logic       stb_h   [0:63];
    logic [7:0] adr_h   [0:63];
    logic       busy_h  [0:63];
    logic       done_h  [0:63];
    logic       tout_h  [0:63];
    logic       valid_h [0:63];
    logic       any_h   [0:63];

    int passed = 0;
    int total  = 0;

    function automatic logic [15:0] out_by_index(input int i);
        case (i)
            0: return row_column_number;
            1: return mine_num;
            2: return timer_seconds;
            3: return field_size;
            4: return board_size;
            5: return board_xpos;
            6: return board_ypos;
            7: return games_won;
            default: return games_lost;
        endcase
    endfunction

    task automatic push_expected();
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            e.adr = addr_tbl[i];
            e.dat = mem[addr_tbl[i]];
            exp_q.push_back(e);
        end
    endtask

    // Pulses fetch in cycle 0, then runs n cycles recording DUT behaviour.
    // stall is high in cycles [s_from, s_to]; a second fetch pulse and a reset
    // pulse can be injected at the given cycles (-1 = none).
    task automatic run_window(input int n, input int s_from, input int s_to,
                              input int refetch_cyc, input int rst_cyc);
        ack_q.delete();
        @(posedge clk); #1;
        fetch = 1'b1; rst = 1'b0; stall = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                fetch = (c == refetch_cyc);
                rst   = (c == rst_cyc);
                stall = (c >= s_from) && (c <= s_to);
            end
            @(negedge clk);
            stb_h[c]   = gs.stb_o;
            adr_h[c]   = gs.adr_o;
            busy_h[c]  = busy;
            done_h[c]  = done;
            tout_h[c]  = timeout_err;
            valid_h[c] = settings_valid;
            any_h[c]   = |{row_column_number, mine_num, timer_seconds, field_size,
                           board_size, board_xpos, board_ypos, games_won, games_lost};
            if (gs.stb_o && gs.ack_i) ack_q.push_back(gs.adr_o);
        end
        @(posedge clk); #1;
        fetch = 1'b0; rst = 1'b0; stall = 1'b0;
    endtask

    // Scoreboard consumer: pops the nine expected reads of one burst.
    task automatic drain_scoreboard(input string name);
        total++;
        if (ack_q.size() !== 9)
            $display("FAIL %s read_count got %0d exp 9", name, ack_q.size());
        else passed++;
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            logic [7:0] got_adr;
            e = exp_q.pop_front();
            got_adr = (i < ack_q.size()) ? ack_q[i] : 8'hFF;
            total++;
            if (got_adr !== e.adr)
                $display("FAIL %s adr[%0d] got %h exp %h", name, i, got_adr, e.adr);
            else passed++;
            total++;
            if (out_by_index(i) !== e.dat)
                $display("FAIL %s data[%0d] got %h exp %h", name, i, out_by_index(i), e.dat);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({gs.stb_o, gs.we_o, gs.adr_o} !== 10'h000)
            $display("FAIL reset_bus got %b exp 0", {gs.stb_o, gs.we_o, gs.adr_o});
        else passed++;
        total++;
        if ({busy, settings_valid, done, timeout_err} !== 4'b0000)
            $display("FAIL reset_flags got %b exp 0000", {busy, settings_valid, done, timeout_err});
        else passed++;
        total++;
        if (|{row_column_number, mine_num, timer_seconds, field_size, board_size,
              board_xpos, board_ypos, games_won, games_lost} !== 1'b0)
            $display("FAIL reset_outputs got nonzero exp 0");
        else passed++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [21:0] stb_obs, stb_exp;
        int ndone;
        push_expected();
        run_window(22, 1, 0, -1, -1);
        drain_scoreboard("basic");
        stb_obs = '0; stb_exp = '0; ndone = 0;
        for (int c = 0; c < 22; c++) begin
            stb_obs[c] = stb_h[c];
            stb_exp[c] = (c % 2 == 1) && (c <= 17);
            ndone += int'(done_h[c]);
        end
        total++;
        if (stb_obs !== stb_exp) $display("FAIL basic_stb_pattern got %b exp %b", stb_obs, stb_exp);
        else passed++;
        total++;
        if (done_h[19] !== 1'b1 || ndone != 1)
            $display("FAIL basic_done got done19=%b count=%0d exp 1/1", done_h[19], ndone);
        else passed++;
        total++;
        if ({valid_h[18], valid_h[19], busy_h[18], busy_h[19]} !== 4'b0110)
            $display("FAIL basic_valid_busy got %b exp 0110",
                     {valid_h[18], valid_h[19], busy_h[18], busy_h[19]});
        else passed++;
    endtask

    task automatic test_stall();
        int held;
        push_expected();
        run_window(27, 1, 5, -1, -1);
        drain_scoreboard("stall");
        held = 0;
        for (int c = 1; c <= 6; c++) held += int'(stb_h[c] && adr_h[c] == 8'h00);
        total++;
        if (held != 6) $display("FAIL stall_hold got %0d exp 6", held);
        else passed++;
        total++;
        if ({done_h[23], done_h[24], valid_h[24]} !== 3'b011)
            $display("FAIL stall_done got %b exp 011", {done_h[23], done_h[24], valid_h[24]});
        else passed++;
    endtask

    task automatic test_timeout();
        int held, ndone;
        run_window(22, 1, 999, -1, -1);
        held = 0; ndone = 0;
        for (int c = 1; c <= 16; c++) held += int'(stb_h[c] && adr_h[c] == 8'h00);
        for (int c = 0; c < 22; c++) ndone += int'(done_h[c]);
        total++;
        if (held != 16) $display("FAIL timeout_hold got %0d exp 16", held);
        else passed++;
        total++;
        if ({tout_h[16], tout_h[17], busy_h[16], busy_h[17], stb_h[17]} !== 5'b01100)
            $display("FAIL timeout_edge got %b exp 01100",
                     {tout_h[16], tout_h[17], busy_h[16], busy_h[17], stb_h[17]});
        else passed++;
        total++;
        if (valid_h[21] !== 1'b0 || ndone != 0 || tout_h[21] !== 1'b1)
            $display("FAIL timeout_status got valid=%b done_count=%0d tout=%b exp 0/0/1",
                     valid_h[21], ndone, tout_h[21]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int ndone, nstb;
        push_expected();
        run_window(26, 1, 0, 5, -1);
        drain_scoreboard("refetch");
        ndone = 0; nstb = 0;
        for (int c = 0; c < 26; c++) begin
            ndone += int'(done_h[c]);
            nstb  += int'(stb_h[c]);
        end
        total++;
        if (ndone != 1 || done_h[19] !== 1'b1 || nstb != 9)
            $display("FAIL refetch_single_burst got done=%0d stb=%0d exp 1/9", ndone, nstb);
        else passed++;
        total++;
        if (tout_h[1] !== 1'b0) $display("FAIL refetch_tout_clear got %b exp 0", tout_h[1]);
        else passed++;
    endtask

    task automatic test_update();
        logic [17:0] v_obs;
        mem[8'h10] = 16'd4;
        push_expected();
        run_window(22, 1, 0, -1, -1);
        drain_scoreboard("update");
        v_obs = '0;
        for (int c = 1; c <= 18; c++) v_obs[c-1] = valid_h[c];
        total++;
        if (v_obs !== 18'h0 || valid_h[19] !== 1'b1)
            $display("FAIL update_valid got %b/%b exp 0/1", v_obs, valid_h[19]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int resumed;
        run_window(14, 1, 0, -1, 9);
        total++;
        if ({busy_h[9], stb_h[10], busy_h[10], any_h[10], valid_h[10]} !== 5'b10000)
            $display("FAIL midrst_clear got %b exp 10000",
                     {busy_h[9], stb_h[10], busy_h[10], any_h[10], valid_h[10]});
        else passed++;
        resumed = 0;
        for (int c = 10; c < 14; c++) resumed += int'(stb_h[c] || busy_h[c]);
        total++;
        if (resumed != 0) $display("FAIL midrst_no_resume got %0d exp 0", resumed);
        else passed++;
        push_expected();
        run_window(22, 1, 0, -1, -1);
        drain_scoreboard("after_rst");
        total++;
        if (done_h[19] !== 1'b1) $display("FAIL after_rst_done got %b exp 1", done_h[19]);
        else passed++;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        mem[8'h00] = 16'h0909; mem[8'h02] = 16'h000A; mem[8'h04] = 16'h03E7;
        mem[8'h06] = 16'hBAD0; mem[8'h08] = 16'h0006; mem[8'h0A] = 16'h0120;
        mem[8'h0C] = 16'h0040; mem[8'h0E] = 16'h0030; mem[8'h10] = 16'h0003;
        mem[8'h12] = 16'hDEAD;
        slave_dat = 16'h0000;
        rst = 1'b1; fetch = 1'b0; stall = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_update();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
